// File: rtl/sc_lives_fsm.sv
// Frog-game lives controller: filters crash samples, counts lives, times respawn.
// Define SC_LIVESFSM_BLINK_EN to build the respawn blink counter; otherwise blink is tied low.
module sc_lives_fsm #(
  parameter int LIVES_INIT    = 3,
  parameter int CRASH_FILTER  = 2,
  parameter int RESPAWN_TICKS = 25000000,
  parameter int BLINK_HALF    = 3125000
) (
  input  logic       SC_LIVESFSM_CLOCK_50,
  input  logic       SC_LIVESFSM_RESET_InHigh,
  input  logic       SC_LIVESFSM_crash_InLow,
  input  logic       SC_LIVESFSM_goal_InHigh,
  input  logic       SC_LIVESFSM_start_InLow,
  output logic [2:0] SC_LIVESFSM_state_OutBUS,
  output logic [1:0] SC_LIVESFSM_lives_OutBUS,
  output logic       SC_LIVESFSM_frogreset_OutHigh,
  output logic       SC_LIVESFSM_gameover_OutHigh,
  output logic       SC_LIVESFSM_win_OutHigh,
  output logic       SC_LIVESFSM_blink_OutHigh
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLAY     = 3'd1,
    HIT      = 3'd2,
    RESPAWN  = 3'd3,
    GAMEOVER = 3'd4,
    WIN      = 3'd5
  } stateT;

  localparam logic [1:0]  LIVES_RST   = 2'(LIVES_INIT);
  localparam logic [3:0]  FILTER_LAST = 4'(CRASH_FILTER - 1);
  localparam logic [25:0] TIMER_LOAD  = 26'(RESPAWN_TICKS - 1);

  stateT       state;
  stateT       nextState;
  logic [1:0]  livesQ;
  logic [3:0]  filterCnt;
  logic [25:0] timer;
  logic        startPrev;
  logic        startArmed;
  logic        frogQ;
  logic        gameoverQ;
  logic        winQ;
  logic        startEvent;
  logic        crashConfirm;

  // startArmed stays low until the button has been seen released after reset,
  // so a button held through reset cannot count as a press.
  always_comb begin
    startEvent   = startArmed & startPrev & ~SC_LIVESFSM_start_InLow;
    crashConfirm = ~SC_LIVESFSM_crash_InLow & (filterCnt == FILTER_LAST);
    nextState    = state;
    case (state)
      IDLE:     if (startEvent) nextState = PLAY;
      PLAY: begin
        if (crashConfirm) nextState = HIT;
        else if (SC_LIVESFSM_goal_InHigh) nextState = WIN;
      end
      HIT:      nextState = (livesQ == 2'd1) ? GAMEOVER : RESPAWN;
      RESPAWN:  if (timer == 26'd0) nextState = PLAY;
      GAMEOVER: if (startEvent) nextState = IDLE;
      WIN:      if (startEvent) nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  always_ff @(posedge SC_LIVESFSM_CLOCK_50 or posedge SC_LIVESFSM_RESET_InHigh) begin
    if (SC_LIVESFSM_RESET_InHigh) begin
      state      <= IDLE;
      livesQ     <= LIVES_RST;
      filterCnt  <= 4'd0;
      timer      <= 26'd0;
      startPrev  <= 1'b1;
      startArmed <= 1'b0;
      frogQ      <= 1'b0;
      gameoverQ  <= 1'b0;
      winQ       <= 1'b0;
    end else begin
      state     <= nextState;
      startPrev <= SC_LIVESFSM_start_InLow;
      if (SC_LIVESFSM_start_InLow) startArmed <= 1'b1;
      frogQ     <= ((state == IDLE) && (nextState == PLAY)) ||
                   ((state != RESPAWN) && (nextState == RESPAWN));
      gameoverQ <= (nextState == GAMEOVER);
      winQ      <= (nextState == WIN);

      // Lives drop on the edge leaving HIT, so HIT still shows the pre-hit count.
      if (nextState == IDLE) livesQ <= LIVES_RST;
      else if ((state == HIT) && (livesQ != 2'd0)) livesQ <= livesQ - 2'd1;

      if ((state == PLAY) && (nextState == PLAY) && ~SC_LIVESFSM_crash_InLow)
        filterCnt <= filterCnt + 4'd1;
      else
        filterCnt <= 4'd0;

      if ((state == HIT) && (nextState == RESPAWN)) timer <= TIMER_LOAD;
      else if ((state == RESPAWN) && (timer != 26'd0)) timer <= timer - 26'd1;
    end
  end

`ifdef SC_LIVESFSM_BLINK_EN
  localparam logic [25:0] BLINK_LAST = 26'(BLINK_HALF - 1);

  logic [25:0] blinkCnt;
  logic        blinkQ;

  always_ff @(posedge SC_LIVESFSM_CLOCK_50 or posedge SC_LIVESFSM_RESET_InHigh) begin
    if (SC_LIVESFSM_RESET_InHigh) begin
      blinkCnt <= 26'd0;
      blinkQ   <= 1'b0;
    end else if (nextState == RESPAWN) begin
      if (state != RESPAWN) begin
        blinkCnt <= 26'd0;
        blinkQ   <= 1'b1;
      end else if (blinkCnt == BLINK_LAST) begin
        blinkCnt <= 26'd0;
        blinkQ   <= ~blinkQ;
      end else begin
        blinkCnt <= blinkCnt + 26'd1;
      end
    end else begin
      blinkCnt <= 26'd0;
      blinkQ   <= 1'b0;
    end
  end

  assign SC_LIVESFSM_blink_OutHigh = blinkQ;
`else
  // Constant 0; the AND only keeps BLINK_HALF referenced in this build.
  assign SC_LIVESFSM_blink_OutHigh = 1'b0 & (BLINK_HALF != 0);
`endif

  assign SC_LIVESFSM_state_OutBUS      = state;
  assign SC_LIVESFSM_lives_OutBUS      = livesQ;
  assign SC_LIVESFSM_frogreset_OutHigh = frogQ;
  assign SC_LIVESFSM_gameover_OutHigh  = gameoverQ;
  assign SC_LIVESFSM_win_OutHigh       = winQ;

endmodule

// File: tb/tb_sc_lives_fsm.sv
// Bench for sc_lives_fsm: directed game scenarios plus random play, checked
// every cycle against a rule-level model of the lives game.
module tb_sc_lives_fsm;

  localparam int LIVES_INIT    = 3;
  localparam int CRASH_FILTER  = 2;
  localparam int RESPAWN_TICKS = 4;
  localparam int BLINK_HALF    = 1;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       crashIn = 1'b1;
  logic       goalIn  = 1'b0;
  logic       startIn = 1'b1;
  logic [2:0] stateOut;
  logic [1:0] livesOut;
  logic       frogOut;
  logic       gameoverOut;
  logic       winOut;
  logic       blinkOut;

  int checks   = 0;
  int failures = 0;

  // Model of the game rules: state codes, lives, crash streak, respawn cycles left.
  int mState;
  int mLives;
  int mStreak;
  int mLeft;
  bit mFrog;
  bit mPrevStart;
  bit mArmed;

  sc_lives_fsm #(
    .LIVES_INIT   (LIVES_INIT),
    .CRASH_FILTER (CRASH_FILTER),
    .RESPAWN_TICKS(RESPAWN_TICKS),
    .BLINK_HALF   (BLINK_HALF)
  ) dut (
    .SC_LIVESFSM_CLOCK_50         (clk),
    .SC_LIVESFSM_RESET_InHigh     (rst),
    .SC_LIVESFSM_crash_InLow      (crashIn),
    .SC_LIVESFSM_goal_InHigh      (goalIn),
    .SC_LIVESFSM_start_InLow      (startIn),
    .SC_LIVESFSM_state_OutBUS     (stateOut),
    .SC_LIVESFSM_lives_OutBUS     (livesOut),
    .SC_LIVESFSM_frogreset_OutHigh(frogOut),
    .SC_LIVESFSM_gameover_OutHigh (gameoverOut),
    .SC_LIVESFSM_win_OutHigh      (winOut),
    .SC_LIVESFSM_blink_OutHigh    (blinkOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mState     = 0;
    mLives     = LIVES_INIT;
    mStreak    = 0;
    mLeft      = 0;
    mFrog      = 1'b0;
    mPrevStart = 1'b1;
    mArmed     = 1'b0;
  endtask

  function automatic int expBlink();
`ifdef SC_LIVESFSM_BLINK_EN
    if (mState == 3) return ((((RESPAWN_TICKS - mLeft) / BLINK_HALF) % 2) == 0) ? 1 : 0;
`endif
    return 0;
  endfunction

  task automatic modelStep();
    bit startEv;
    startEv = mArmed && mPrevStart && !startIn;
    if (startIn) mArmed = 1'b1;
    mPrevStart = startIn;
    mFrog = 1'b0;
    case (mState)
      0: begin
        mLives = LIVES_INIT;
        if (startEv) begin mState = 1; mFrog = 1'b1; mStreak = 0; end
      end
      1: begin
        mStreak = crashIn ? 0 : mStreak + 1;
        if (mStreak >= CRASH_FILTER) begin mState = 2; mStreak = 0; end
        else if (goalIn) begin mState = 5; mStreak = 0; end
      end
      2: begin
        if (mLives == 1) mState = 4;
        else begin mState = 3; mLeft = RESPAWN_TICKS; mFrog = 1'b1; end
        if (mLives > 0) mLives = mLives - 1;
      end
      3: begin
        mLeft = mLeft - 1;
        if (mLeft == 0) begin mState = 1; mStreak = 0; end
      end
      default: if (startEv) begin mState = 0; mLives = LIVES_INIT; end
    endcase
  endtask

  task automatic checkAll(input string tag);
    check({tag, ".state"},    32'(stateOut),    32'(mState));
    check({tag, ".lives"},    32'(livesOut),    32'(mLives));
    check({tag, ".frog"},     32'(frogOut),     32'(mFrog));
    check({tag, ".gameover"}, 32'(gameoverOut), (mState == 4) ? 32'd1 : 32'd0);
    check({tag, ".win"},      32'(winOut),      (mState == 5) ? 32'd1 : 32'd0);
    check({tag, ".blink"},    32'(blinkOut),    32'(expBlink()));
  endtask

  // Inputs change only at posedge+1, so the model sees the values the DUT clocked.
  task automatic tick(input string tag);
    @(posedge clk);
    modelStep();
    #1;
    checkAll(tag);
  endtask

  task automatic drive(input logic c, input logic g, input logic s, input string tag);
    crashIn = c;
    goalIn  = g;
    startIn = s;
    tick(tag);
  endtask

  task automatic pressStart(input string tag);
    drive(1'b1, 1'b0, 1'b0, tag);
    drive(1'b1, 1'b0, 1'b1, tag);
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, "armIdle");
    drive(1'b1, 1'b0, 1'b1, "armIdle");

    // Start press enters PLAY with one frog reset pulse.
    drive(1'b1, 1'b0, 1'b0, "startPress");
    check("startPress.constState", 32'(stateOut), 32'd1);
    check("startPress.constFrog", 32'(frogOut), 32'd1);
    drive(1'b1, 1'b0, 1'b0, "startHeld");
    check("startHeld.constFrog", 32'(frogOut), 32'd0);
    drive(1'b1, 1'b0, 1'b1, "startRelease");

    // Broken crash streaks never confirm; two in a row do.
    drive(1'b0, 1'b0, 1'b1, "filterLow");
    drive(1'b1, 1'b0, 1'b1, "filterHigh");
    drive(1'b0, 1'b0, 1'b1, "filterLow");
    drive(1'b1, 1'b0, 1'b1, "filterHigh");
    check("filterBroken.constState", 32'(stateOut), 32'd1);
    drive(1'b0, 1'b0, 1'b1, "hit1a");
    drive(1'b0, 1'b0, 1'b1, "hit1b");
    check("hit1.constState", 32'(stateOut), 32'd2);
    drive(1'b1, 1'b0, 1'b1, "respawn1");
    check("respawn1.constLives", 32'(livesOut), 32'd2);
    check("respawn1.constState", 32'(stateOut), 32'd3);
    for (int i = 0; i < RESPAWN_TICKS; i++) drive(1'b0, 1'b1, 1'b1, "respawnIgnore");
    check("respawnDone.constState", 32'(stateOut), 32'd1);

    // Two more hits run lives out.
    for (int h = 0; h < 2; h++) begin
      drive(1'b0, 1'b0, 1'b1, "hitLoopA");
      drive(1'b0, 1'b0, 1'b1, "hitLoopB");
      for (int i = 0; i < RESPAWN_TICKS + 2; i++) drive(1'b1, 1'b0, 1'b1, "hitLoopRun");
    end
    check("gameover.constState", 32'(stateOut), 32'd4);
    check("gameover.constLives", 32'(livesOut), 32'd0);
    check("gameover.constFlag", 32'(gameoverOut), 32'd1);
    pressStart("gameoverExit");
    check("gameoverExit.constState", 32'(stateOut), 32'd0);
    check("gameoverExit.constLives", 32'(livesOut), 32'd3);

    // Crash confirmation beats a simultaneous goal; lone goal wins.
    pressStart("play2");
    drive(1'b0, 1'b0, 1'b1, "tieA");
    drive(1'b0, 1'b1, 1'b1, "tieB");
    check("tie.constState", 32'(stateOut), 32'd2);
    for (int i = 0; i < RESPAWN_TICKS + 2; i++) drive(1'b1, 1'b0, 1'b1, "tieRun");
    drive(1'b1, 1'b1, 1'b1, "goal");
    check("goal.constState", 32'(stateOut), 32'd5);
    check("goal.constWin", 32'(winOut), 32'd1);
    drive(1'b1, 1'b0, 1'b1, "winHold");
    pressStart("winExit");

    // Asynchronous reset two cycles into RESPAWN, start held low across release.
    pressStart("play3");
    drive(1'b0, 1'b0, 1'b1, "preRstA");
    drive(1'b0, 1'b0, 1'b1, "preRstB");
    drive(1'b1, 1'b0, 1'b1, "preRstResp1");
    drive(1'b1, 1'b0, 1'b1, "preRstResp2");
    #3;
    rst     = 1'b1;
    startIn = 1'b0;
    #1;
    modelReset();
    checkAll("asyncRst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, "heldThroughRst");
    check("heldThroughRst.constState", 32'(stateOut), 32'd0);
    drive(1'b1, 1'b0, 1'b1, "releaseAfterRst");
    drive(1'b1, 1'b0, 1'b0, "pressAfterRst");
    check("pressAfterRst.constState", 32'(stateOut), 32'd1);
    drive(1'b1, 1'b0, 1'b1, "releaseAgain");

    // Random play.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1,
            ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1,
            "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
